// File: rtl/banco_registradores_sync.sv
// Parametrised register bank: two registered read ports with write-first bypass,
// one write port, optional hardwired zero entry, and a sequenced bulk clear.
module banco_registradores_sync #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Data1,
    output logic [WIDTH-1:0]  Data2,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] clearCount, clearCountNext;
    logic [WIDTH-1:0]  regs [DEPTH];

    logic              userWrite;
    logic              effWe;
    logic [ADDR_W-1:0] effAddr;
    logic [WIDTH-1:0]  effData;
    logic [WIDTH-1:0]  readNext1, readNext2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clearCount <= '0;
        end else begin
            state      <= stateNext;
            clearCount <= clearCountNext;
        end
    end

    // The clear walks the counter from 0 to DEPTH-1; it wraps back to 0 on exit.
    always_comb begin
        stateNext      = state;
        clearCountNext = clearCount;
        case (state)
            IDLE: begin
                if (Clear) begin
                    stateNext      = CLEAR;
                    clearCountNext = '0;
                end
            end
            CLEAR: begin
                clearCountNext = clearCount + 1'b1;
                if (clearCount == LAST_INDEX) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign Busy = (state == CLEAR);

    // A single effective write per edge: the user write when accepted, else the clear write.
    always_comb begin
        userWrite = RegWrite && (state == IDLE) && !((ZERO_REG != 0) && (WriteReg == '0));
        effWe     = userWrite || (state == CLEAR);
        effAddr   = userWrite ? WriteReg : clearCount;
        effData   = userWrite ? WriteData : '0;
    end

    always_comb begin
        readNext1 = regs[Read1];
        readNext2 = regs[Read2];
        if (effWe && (effAddr == Read1)) begin
            readNext1 = effData;
        end
        if (effWe && (effAddr == Read2)) begin
            readNext2 = effData;
        end
        if ((ZERO_REG != 0) && (Read1 == '0)) begin
            readNext1 = '0;
        end
        if ((ZERO_REG != 0) && (Read2 == '0)) begin
            readNext2 = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            Data1 <= '0;
            Data2 <= '0;
        end else begin
            if (effWe) begin
                regs[effAddr] <= effData;
            end
            Data1 <= readNext1;
            Data2 <= readNext2;
        end
    end

endmodule
